// File: rtl/af_sample_sequencer.sv
// af_sample_sequencer: divides clk to the 3 kHz filter frame, sequences the shared x/d ADC and
// commits both S(8,7) samples atomically. Define AF_SEQ_WATCHDOG_EN to add the ADC watchdog.
module af_sample_sequencer #(
  parameter int unsigned NB_SAMPLE    = 8,
  parameter int unsigned CLK_DIV      = 1800,
  parameter int unsigned NB_DIV       = 11,
  parameter int unsigned FILTER_ORDER = 30,
  parameter int unsigned EN_HIGH      = 4,
  parameter int unsigned ADC_TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_run,
  input  logic                 i_clr,
  input  logic [NB_SAMPLE-1:0] i_adc_data,
  input  logic                 i_adc_valid,
  output logic                 o_adc_start,
  output logic                 o_adc_ch,
  output logic [NB_SAMPLE-1:0] o_xn,
  output logic [NB_SAMPLE-1:0] o_dn,
  output logic                 o_enable,
  output logic                 o_busy,
  output logic                 o_overrun,
  output logic                 o_timeout
);

  localparam int unsigned NbEn = (EN_HIGH > 1) ? $clog2(EN_HIGH) : 1;

  // Frame must leave room for the conversions, the filter MAC and the enable pulse.
  if ((CLK_DIV <= FILTER_ORDER + 4) || (EN_HIGH < 1) || (EN_HIGH > CLK_DIV - FILTER_ORDER - 2) ||
      ((2 ** NB_DIV) < CLK_DIV) || (ADC_TIMEOUT < 1) || (NB_SAMPLE < 2)) begin : g_bad_cfg
    $error("af_sample_sequencer: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    StIdle,
    StReqX,
    StWaitX,
    StReqD,
    StWaitD,
    StCommit
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [NB_DIV-1:0]    r_cnt;
  logic                 w_tick;
  logic [NB_SAMPLE-1:0] w_sample;
  logic [NB_SAMPLE-1:0] r_x_cap;
  logic [NB_SAMPLE-1:0] r_xn;
  logic [NB_SAMPLE-1:0] r_dn;
  logic [NbEn-1:0]      r_en_cnt;
  logic                 r_enable;
  logic                 r_overrun;
  logic                 w_overrun_set;
  logic                 w_wd_expired;

  assign w_tick        = (r_cnt == NB_DIV'(CLK_DIV - 1)) && i_run;
  assign w_overrun_set = w_tick && (r_state != StIdle);
  // Offset-binary to two's complement: flip the MSB.
  assign w_sample      = {~i_adc_data[NB_SAMPLE-1], i_adc_data[NB_SAMPLE-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + NB_DIV'(1);
    end
  end

`ifdef AF_SEQ_WATCHDOG_EN
  localparam int unsigned NbWd = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;

  logic [NbWd-1:0] r_wd_cnt;
  logic            w_waiting;
  logic            r_timeout;

  assign w_waiting    = (r_state == StWaitX) || (r_state == StWaitD);
  assign w_wd_expired = w_waiting && !i_adc_valid && (r_wd_cnt == NbWd'(ADC_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (!w_waiting || i_adc_valid) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + NbWd'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_wd_expired) begin
      r_timeout <= 1'b1;
    end else if (i_clr) begin
      r_timeout <= 1'b0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_wd_expired = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_tick) w_state_next = StReqX;
      end
      StReqX:  w_state_next = StWaitX;
      StWaitX: begin
        if (i_adc_valid) w_state_next = StReqD;
        else if (w_wd_expired) w_state_next = StIdle;
      end
      StReqD:  w_state_next = StWaitD;
      StWaitD: begin
        if (i_adc_valid) w_state_next = StCommit;
        else if (w_wd_expired) w_state_next = StIdle;
      end
      StCommit: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // x is staged so both outputs change on the same edge, entering COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_cap <= '0;
      r_xn    <= '0;
      r_dn    <= '0;
    end else if (i_adc_valid) begin
      if (r_state == StWaitX) begin
        r_x_cap <= w_sample;
      end
      if (r_state == StWaitD) begin
        r_xn <= r_x_cap;
        r_dn <= w_sample;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_cnt <= '0;
      r_enable <= 1'b0;
    end else if (r_state == StCommit) begin
      r_en_cnt <= NbEn'(EN_HIGH - 1);
      r_enable <= 1'b1;
    end else if (r_en_cnt != '0) begin
      r_en_cnt <= r_en_cnt - NbEn'(1);
    end else begin
      r_enable <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (i_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_adc_start = (r_state == StReqX) || (r_state == StReqD);
  assign o_adc_ch    = (r_state == StReqD) || (r_state == StWaitD);
  assign o_busy      = (r_state != StIdle);
  assign o_xn        = r_xn;
  assign o_dn        = r_dn;
  assign o_enable    = r_enable;
  assign o_overrun   = r_overrun;

endmodule
